// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - fetch_state_e : fetch sequencing states
//       FETCH : a request is outstanding at the current PC
//       HOLD  : an instruction has been captured while IF/ID is stalled
//       DRAIN : a wrong-path request is still outstanding after a redirect
//   - NOP_INSTR        : bubble value driven when no instruction is delivered
//   - DEFAULT_PC_INCR  : byte step between sequential fetches
//   - DEFAULT_RESET_PC : PC value loaded on reset
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_INCR  = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_pc_select.sv
// ---------------------------------------------------------------------------
// fetch_pc_select
//   Combinational redirect priority and next-PC mux.
//   Priority: branch > jump > fallback (sequential or held PC+4, chosen by
//   the caller).
// Ports:
//   branch_taken_i / branch_target_i : resolved taken branch and destination
//   jump_taken_i   / jump_target_i   : decoded jump and destination
//   fallback_pc_i                    : PC to use when nothing redirects
//   redirect_o                       : branch or jump present this cycle
//   next_pc_o                        : selected next PC
// ---------------------------------------------------------------------------
module fetch_pc_select (
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_taken_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] fallback_pc_i,
  output logic        redirect_o,
  output logic [31:0] next_pc_o
);

  always_comb begin
    redirect_o = branch_taken_i | jump_taken_i;
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (jump_taken_i) begin
      next_pc_o = jump_target_i;
    end else begin
      next_pc_o = fallback_pc_i;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage feeding the IF/ID register. Owns the PC, runs a req/ready
//   handshake to instruction memory, applies branch/jump redirects and
//   hazard stalls, and presents PC+4, the instruction (or a NOP bubble) and
//   the flush strobe to IF/ID.
//
// Handshake: a fetch transfers on a cycle where ImemReq=1 and ImemReady=1.
//   While ImemReq=1 and ImemReady=0, ImemAddr is held stable. ImemReq is
//   never withdrawn mid-transaction except by Rst; a redirect while the
//   request is pending keeps the stale request alive (DRAIN) until it
//   completes, and its data is discarded.
//
// Parameters: RESET_PC (PC after reset), PC_INCR (sequential byte step).
// Ports:
//   Clk, Rst                 : clock, synchronous active-high reset
//   Stall                    : 1 = hold IF (hazard unit)
//   BranchTaken/BranchTarget : taken branch redirect (highest priority)
//   JumpTaken/JumpTarget     : jump redirect
//   ImemReq/ImemAddr         : fetch request to instruction memory
//   ImemReady/ImemData       : memory response
//   outputPCValue            : PC+PC_INCR of delivered instruction, else 0
//   outputInstructionMem     : delivered instruction, else NOP
//   FetchValid               : real instruction delivered this cycle
//   FlushSignal              : IF/ID flush, asserted in redirect cycles
//   dbg_state_o              : current fetch state (fetch_state_e encoding)
// Optional (macro FETCH_PERF_COUNT_EN):
//   FetchCount               : consumed deliveries, wraps mod 2^32
//   FlushCount               : flush cycles, wraps mod 2^32
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INCR  = DEFAULT_PC_INCR
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] outputPCValue,
  output logic [31:0] outputInstructionMem,
  output logic        FetchValid,
  output logic        FlushSignal,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount,
`endif
  output logic [1:0]  dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;

  logic [31:0]  pc_plus;
  logic [31:0]  fallback_pc;
  logic [31:0]  sel_pc;
  logic         redirect;

  assign pc_plus = pc_q + PC_INCR;  // modulo 2^32, wraps silently

  // Where the PC goes when nothing redirects.
  always_comb begin
    fallback_pc = pc_q;
    case (state_q)
      FETCH:   if (ImemReady && !Stall) fallback_pc = pc_plus;
      HOLD:    if (!Stall) fallback_pc = hold_pc4_q;
      default: fallback_pc = pc_q;
    endcase
  end

  fetch_pc_select u_pc_select (
    .branch_taken_i  (BranchTaken),
    .branch_target_i (BranchTarget),
    .jump_taken_i    (JumpTaken),
    .jump_target_i   (JumpTarget),
    .fallback_pc_i   (fallback_pc),
    .redirect_o      (redirect),
    .next_pc_o       (sel_pc)
  );

  // Next-state and output logic.
  always_comb begin
    state_d              = state_q;
    pc_d                 = sel_pc;
    req_addr_d           = req_addr_q;
    hold_instr_d         = hold_instr_q;
    hold_pc4_d           = hold_pc4_q;
    ImemReq              = 1'b0;
    ImemAddr             = req_addr_q;
    outputPCValue        = 32'h0;
    outputInstructionMem = NOP_INSTR;
    FetchValid           = 1'b0;
    FlushSignal          = 1'b0;

    case (state_q)
      FETCH: begin
        ImemReq = 1'b1;
        if (redirect) begin
          FlushSignal = 1'b1;
          // A completing handshake lets us retarget at once; otherwise the
          // stale request must finish first.
          if (ImemReady) req_addr_d = sel_pc;
          else           state_d    = DRAIN;
        end else if (ImemReady && !Stall) begin
          outputInstructionMem = ImemData;
          outputPCValue        = pc_plus;
          FetchValid           = 1'b1;
          req_addr_d           = sel_pc;
        end else if (ImemReady) begin
          hold_instr_d = ImemData;
          hold_pc4_d   = pc_plus;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          FlushSignal = 1'b1;
          req_addr_d  = sel_pc;
          state_d     = FETCH;
        end else begin
          outputInstructionMem = hold_instr_q;
          outputPCValue        = hold_pc4_q;
          FetchValid           = 1'b1;
          if (!Stall) begin
            req_addr_d = sel_pc;
            state_d    = FETCH;
          end
        end
      end

      DRAIN: begin
        ImemReq     = 1'b1;
        FlushSignal = redirect;
        if (ImemReady) begin
          req_addr_d = sel_pc;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    // Reset overrides everything visible, including an in-flight ready.
    if (Rst) begin
      ImemReq              = 1'b0;
      ImemAddr             = 32'h0;
      outputPCValue        = 32'h0;
      outputInstructionMem = NOP_INSTR;
      FetchValid           = 1'b0;
      FlushSignal          = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign dbg_state_o = state_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        consumed;

  // Deliveries only leave IF when Stall is low: FETCH delivers only then,
  // and HOLD delivers every cycle but is consumed on its exit cycle.
  assign consumed = FetchValid & ~Stall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (consumed)    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (FlushSignal) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage directly upstream of the IF/ID pipeline register.
- Owns the PC register and runs a req/ready handshake to instruction memory.
- Applies branch/jump redirects and hazard stalls.
- Presents PC+4, the fetched instruction (or NOP bubble) and the flush strobe to IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INCR, 4, byte increment between sequential fetches.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  from hazard unit; same polarity as IFIDWrite (1 = hold IF).
- BranchTaken  in  1  branch resolved taken this cycle.
- BranchTarget  in  32  branch destination.
- JumpTaken  in  1  jump decoded this cycle.
- JumpTarget  in  32  jump destination.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  32  fetch address; held stable while ImemReq=1 and ImemReady=0.
- ImemReady  in  1  memory returns ImemData this cycle.
- ImemData  in  32  instruction word.
- outputPCValue  out  32  PC+PC_INCR of the delivered instruction; 0 when no instruction is delivered.
- outputInstructionMem  out  32  delivered instruction; 32'h0 (NOP) when no instruction is delivered.
- FetchValid  out  1  a real instruction is delivered this cycle.
- FlushSignal  out  1  to IF/ID flush input.

Behaviour:
- States:
  - FETCH: request outstanding at PC.
  - HOLD: instruction captured; waiting for the stall to release.
  - DRAIN: wrong-path request still outstanding.
- Registers: PC, ReqAddr, HoldInstr, HoldPC4, state.
- Reset (Rst=1 at posedge):
  - PC=ReqAddr=RESET_PC, state=FETCH, HoldInstr=0, HoldPC4=0.
  - While Rst=1: ImemReq=0, FlushSignal=0, FetchValid=0, outputs 0.
- Redirect = BranchTaken | JumpTaken. Branch has priority over jump when both are asserted.
- FETCH, ImemAddr=ReqAddr, ImemReq=1:
  - Redirect (any Stall/ImemReady):
    - FlushSignal=1, FetchValid=0.
    - PC and ReqAddr <= target.
    - If ImemReady=1 the data is discarded and state stays FETCH; else state -> DRAIN. In DRAIN, ReqAddr stays at the old address until the handshake completes, then loads the target.
  - ImemReady=1, Stall=0:
    - Deliver combinationally: outputInstructionMem=ImemData, outputPCValue=PC+PC_INCR, FetchValid=1.
    - PC, ReqAddr <= PC+PC_INCR. Stay FETCH.
  - ImemReady=1, Stall=1: HoldInstr<=ImemData, HoldPC4<=PC+PC_INCR; -> HOLD. No delivery this cycle.
  - ImemReady=0: outputs NOP/0, FetchValid=0.
- HOLD, ImemReq=0:
  - Outputs come from the Hold registers; FetchValid=1.
  - Stall=0: PC, ReqAddr <= HoldPC4; -> FETCH.
  - Redirect: Hold contents dropped, FlushSignal=1, PC/ReqAddr <= target, -> FETCH.
- DRAIN, ImemReq=1 at the stale address:
  - Outputs NOP, FetchValid=0.
  - On ImemReady: data discarded, ReqAddr <= PC, -> FETCH.
  - A further redirect in DRAIN updates PC only and asserts FlushSignal=1.
- FlushSignal is combinational, asserted only in redirect cycles. Redirect overrides Stall.
- Arithmetic: PC increment is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Target low 2 bits are passed through unchanged.
- Reset mid-transaction (any state) returns to FETCH. Any in-flight ImemReady in the reset cycle is ignored.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined:
  - Adds outputs FetchCount[31:0] (increments per FetchValid=1 cycle whose delivery is consumed, i.e. FETCH with Stall=0, or HOLD exiting).
  - Adds FlushCount[31:0] (increments per FlushSignal=1 cycle).
  - Both clear on Rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - state enum {FETCH, HOLD, DRAIN}.
  - NOP_INSTR=32'h0, PC_INCR default, RESET_PC default.
- Sub-module fetch_pc_select: combinational redirect priority and next-PC mux (branch > jump > sequential/hold).
- FSM and registers stay in the top.

Test Plan:
- Reset, ImemReady tied 1, no stall: cycle 1 delivers addr 0, then 4, 8, 12. Each outputPCValue = addr+4, FetchValid=1.
- ImemReady asserted every 3rd cycle: ImemAddr is stable between handshakes; NOP with FetchValid=0 on the non-ready cycles.
- Stall=1 when ImemReady arrives for addr 0x10: HOLD outputs 0x14 plus the instruction for 2 cycles; Stall=0 then next ImemAddr=0x14.
- BranchTaken with BranchTarget=0x40 while a request at 0x20 is pending: FlushSignal=1 for one cycle; the 0x20 data is dropped on ready; next ImemAddr=0x40.
- BranchTaken=1 and JumpTaken=1 together (0x80 / 0xC0) with Stall=1: PC=0x80 and FlushSignal=1 despite the stall.
- Rst asserted in HOLD: next cycle FETCH at RESET_PC with outputs 0; with FETCH_PERF_COUNT_EN, both counters read 0.
